// File: rtl/codec_pkg.sv
// Shared 4B5B definitions for the codificador/decodificador pair:
// code table, IDLE symbol and the receive lock state type.
package codec_pkg;

  localparam logic [4:0] SYM_IDLE = 5'b11111;

  // Index is the nibble value, entry is its 5-bit line symbol.
  localparam logic [4:0] SYM_TABLE [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101,
    5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111,
    5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

endpackage

// File: rtl/decodificador_if.sv
// Symbol-in / nibble-out bundle between the symbol source, the decoder and
// the nibble consumers.
interface decodificador_if #(
  parameter int ERR_W = 4
);
  logic             m1, m2, m3, m4, m5;
  logic             ready;
  logic             a, b, c, d;
  logic             valid;
  logic             idle;
  logic             error;
  logic             locked;
  logic [ERR_W-1:0] err_count;

  modport master (
    output m1, m2, m3, m4, m5, ready,
    input  a, b, c, d, valid, idle, error, locked, err_count
  );

  modport slave (
    input  m1, m2, m3, m4, m5, ready,
    output a, b, c, d, valid, idle, error, locked, err_count
  );
endinterface

// File: rtl/decodificador_sym_lookup.sv
// Combinational reverse lookup of a 5-bit 4B5B symbol into its nibble,
// with data/IDLE classification; anything else is invalid.
module sym_lookup
  import codec_pkg::*;
(
  input  logic [4:0] sym_i,
  output logic [3:0] nibble_o,
  output logic       is_data_o,
  output logic       is_idle_o
);

  always_comb begin
    nibble_o  = 4'd0;
    is_data_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (sym_i == SYM_TABLE[i]) begin
        nibble_o  = 4'(i);
        is_data_o = 1'b1;
      end
    end
  end

  assign is_idle_o = (sym_i == SYM_IDLE);

endmodule

// File: rtl/decodificador.sv
// Registered 4B5B decoder with a lock FSM that withholds data and error
// reporting until an IDLE has been seen on the line.
module decodificador
  import codec_pkg::*;
#(
  parameter int ERR_W     = 4,
  parameter int LOCK_ERRS = 3
) (
  input  logic            clk,
  input  logic            reset,
  decodificador_if.slave  bus
);

  localparam logic [3:0] LOCK_LIM = 4'(LOCK_ERRS);

  logic [4:0]       sym;
  logic [3:0]       nibble;
  logic             is_data;
  logic             is_idle;

  lock_state_t      state_q;
  logic [3:0]       nibble_q;
  logic             valid_q;
  logic             idle_q;
  logic             error_q;
  logic [ERR_W-1:0] err_count_q;
  logic [ERR_W-1:0] err_count_d;
  logic [3:0]       cons_q;
  logic [3:0]       cons_d;

  assign sym = {bus.m1, bus.m2, bus.m3, bus.m4, bus.m5};

  sym_lookup u_lookup (
    .sym_i     (sym),
    .nibble_o  (nibble),
    .is_data_o (is_data),
    .is_idle_o (is_idle)
  );

  assign err_count_d = (&err_count_q) ? err_count_q : ERR_W'(err_count_q + 1'b1);
  assign cons_d      = cons_q + 4'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= UNLOCKED;
      nibble_q    <= 4'd0;
      valid_q     <= 1'b0;
      idle_q      <= 1'b0;
      error_q     <= 1'b0;
      err_count_q <= '0;
      cons_q      <= 4'd0;
    end else begin
      valid_q <= 1'b0;
      idle_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.ready) begin
        case (state_q)
          UNLOCKED: begin
            // Only IDLE is trusted before lock; everything else is dropped.
            if (is_idle) begin
              state_q <= LOCKED;
              idle_q  <= 1'b1;
            end
          end
          LOCKED: begin
            if (is_data) begin
              nibble_q <= nibble;
              valid_q  <= 1'b1;
              cons_q   <= 4'd0;
            end else if (is_idle) begin
              idle_q <= 1'b1;
              cons_q <= 4'd0;
            end else begin
              error_q     <= 1'b1;
              err_count_q <= err_count_d;
              if (cons_d >= LOCK_LIM) begin
                state_q <= UNLOCKED;
                cons_q  <= 4'd0;
              end else begin
                cons_q <= cons_d;
              end
            end
          end
          default: state_q <= UNLOCKED;
        endcase
      end
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d} = nibble_q;
  assign bus.valid     = valid_q;
  assign bus.idle      = idle_q;
  assign bus.error     = error_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_decodificador.sv
// Directed bench for decodificador: a default instance and an ERR_W=2
// instance fed the same symbol stream.
module tb_decodificador;

  logic clk;
  logic reset;

  int checks   = 0;
  int failures = 0;

  localparam logic [4:0] TB_TAB [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101,
    5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111,
    5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  decodificador_if #(.ERR_W(4)) bus  ();
  decodificador_if #(.ERR_W(2)) bus2 ();

  decodificador #(.ERR_W(4), .LOCK_ERRS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  decodificador #(.ERR_W(2), .LOCK_ERRS(3)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one symbol on both instances at a falling edge; returns at the
  // next falling edge, when that symbol's registered results are visible.
  task automatic sym(input logic [4:0] s, input logic rdy);
    {bus.m1, bus.m2, bus.m3, bus.m4, bus.m5}      = s;
    {bus2.m1, bus2.m2, bus2.m3, bus2.m4, bus2.m5} = s;
    bus.ready  = rdy;
    bus2.ready = rdy;
    @(negedge clk);
  endtask

  function automatic int nib();
    return int'({bus.a, bus.b, bus.c, bus.d});
  endfunction

  task automatic chk_pulses(input string tag, input int v, input int i, input int e);
    chk({tag, ".valid"}, int'(bus.valid), v);
    chk({tag, ".idle"},  int'(bus.idle),  i);
    chk({tag, ".error"}, int'(bus.error), e);
  endtask

  initial begin
    reset = 1'b0;
    {bus.m1, bus.m2, bus.m3, bus.m4, bus.m5}      = 5'b00000;
    {bus2.m1, bus2.m2, bus2.m3, bus2.m4, bus2.m5} = 5'b00000;
    bus.ready  = 1'b0;
    bus2.ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.nibble", nib(), 0);
    chk_pulses("rst", 0, 0, 0);
    chk("rst.locked", int'(bus.locked), 0);
    chk("rst.err_count", int'(bus.err_count), 0);
    reset = 1'b1;
    @(negedge clk);

    // Unlocked: data and invalid symbols are discarded
    sym(5'b01001, 1'b1);
    chk_pulses("unl_data", 0, 0, 0);
    chk("unl_data.locked", int'(bus.locked), 0);
    chk("unl_data.err_count", int'(bus.err_count), 0);
    sym(5'b00000, 1'b1);
    chk_pulses("unl_inv", 0, 0, 0);
    chk("unl_inv.err_count", int'(bus.err_count), 0);

    // Lock, then all sixteen data symbols back-to-back
    sym(5'b11111, 1'b1);
    chk_pulses("lock", 0, 1, 0);
    chk("lock.locked", int'(bus.locked), 1);
    for (int i = 0; i < 16; i++) begin
      sym(TB_TAB[i], 1'b1);
      chk($sformatf("data%0d.valid", i), int'(bus.valid), 1);
      chk($sformatf("data%0d.nibble", i), nib(), i);
    end

    // Errors interleaved with data while locked
    sym(5'b00000, 1'b1);
    chk_pulses("e1", 0, 0, 1);
    chk("e1.err_count", int'(bus.err_count), 1);
    sym(5'b11110, 1'b1);
    chk_pulses("e1d", 1, 0, 0);
    chk("e1d.nibble", nib(), 0);
    sym(5'b00000, 1'b1);
    chk_pulses("e2", 0, 0, 1);
    chk("e2.err_count", int'(bus.err_count), 2);
    chk("e2.locked", int'(bus.locked), 1);

    // ready low: nothing changes, IDLE ignored
    sym(5'b11111, 1'b0);
    chk_pulses("nordy", 0, 0, 0);
    chk("nordy.nibble", nib(), 0);
    chk("nordy.err_count", int'(bus.err_count), 2);

    // IDLE clears the consecutive count, then three errors drop lock
    sym(5'b11111, 1'b1);
    chk_pulses("idle2", 0, 1, 0);
    for (int k = 1; k <= 3; k++) begin
      sym(5'b00001, 1'b1);
      chk($sformatf("drop%0d.error", k), int'(bus.error), 1);
      chk($sformatf("drop%0d.err_count", k), int'(bus.err_count), 2 + k);
      chk($sformatf("drop%0d.locked", k), int'(bus.locked), (k < 3) ? 1 : 0);
    end
    chk("drop.err_count_w2", int'(bus2.err_count), 3);
    sym(5'b11110, 1'b1);
    chk_pulses("after_drop", 0, 0, 0);
    sym(5'b11111, 1'b1);
    chk_pulses("relock", 0, 1, 0);
    chk("relock.locked", int'(bus.locked), 1);

    // Asynchronous reset mid-stream with nibble B on the outputs
    sym(5'b10111, 1'b1);
    chk("preRst.nibble", nib(), 11);
    #2 reset = 1'b0;
    #1;
    chk("arst.nibble", nib(), 0);
    chk_pulses("arst", 0, 0, 0);
    chk("arst.locked", int'(bus.locked), 0);
    chk("arst.err_count", int'(bus.err_count), 0);
    @(negedge clk);
    reset = 1'b1;
    sym(5'b10111, 1'b1);
    chk_pulses("postRst", 0, 0, 0);
    chk("postRst.locked", int'(bus.locked), 0);
    chk("postRst.err_count", int'(bus.err_count), 0);

    // Saturation on the ERR_W=2 instance, errors separated by data
    sym(5'b11111, 1'b1);
    chk("sat.locked", int'(bus2.locked), 1);
    for (int k = 1; k <= 5; k++) begin
      sym(5'b00000, 1'b1);
      chk($sformatf("sat%0d.error", k), int'(bus2.error), 1);
      chk($sformatf("sat%0d.err_count_w2", k), int'(bus2.err_count), (k < 3) ? k : 3);
      chk($sformatf("sat%0d.err_count_w4", k), int'(bus.err_count), k);
      sym(5'b01001, 1'b1);
      chk($sformatf("sat%0d.valid", k), int'(bus2.valid), 1);
      chk($sformatf("sat%0d.nibble", k), nib(), 1);
    end
    chk("sat.locked_end", int'(bus2.locked), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decodificador.md
# decodificador

Registered 4B5B symbol decoder: the receive-side counterpart of the `codificador` block. Each cycle with `ready` high, one 5-bit symbol (`m1`..`m5`) is accepted. The block translates it back to the 4-bit nibble (`a`..`d`) and flags idle or invalid symbols. A small lock state machine keeps garbage from reaching the data outputs until the line is known good. It sits directly after the symbol source and feeds nibble consumers through a one-cycle `valid` pulse.

## Interface
Parameters:
- `ERR_W`, 4: width of the saturating error counter.
- `LOCK_ERRS`, 3: number of consecutive invalid symbols that drops lock (legal range 1..15).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; low clears all state immediately.
- `m1`..`m5`  in  1 each  symbol bits; `m1` is the MSB.
- `ready`  in  1  symbol qualifier; the symbol is accepted on each rising edge where `ready`=1.
- `a`,`b`,`c`,`d`  out  1 each  decoded nibble; `a` is the MSB.
- `valid`  out  1  one-cycle pulse: `a`..`d` carry a newly decoded nibble.
- `idle`  out  1  one-cycle pulse: the accepted symbol was IDLE (11111).
- `error`  out  1  one-cycle pulse: the accepted symbol was invalid.
- `locked`  out  1  FSM is in LOCKED.
- `err_count`  out  ERR_W  total invalid symbols seen while LOCKED; saturates at all-ones.

## Operation
- Code table, data symbols (hex nibble = symbol): 0=11110, 1=01001, 2=10100, 3=10101, 4=01010, 5=01011, 6=01110, 7=01111, 8=10010, 9=10011, A=10110, B=10111, C=11010, D=11011, E=11100, F=11101.
- IDLE symbol = 11111.
- Every other 5-bit value is invalid.
- FSM states are UNLOCKED and LOCKED. The reset state is UNLOCKED.
- UNLOCKED behaviour:
  - An accepted IDLE moves the FSM to LOCKED and pulses `idle`.
  - Data symbols and invalid symbols are discarded: no `valid`, no `error`, and no change to `err_count`.
- LOCKED, data symbol: registers the nibble on `a`..`d`, pulses `valid`, and clears the consecutive-error counter.
- LOCKED, IDLE: pulses `idle` and clears the consecutive-error counter.
- LOCKED, invalid symbol:
  - Pulses `error`.
  - Increments `err_count`, saturating.
  - Increments the consecutive-error counter.
  - When the consecutive-error counter reaches `LOCK_ERRS`, the FSM moves to UNLOCKED on the same edge and the consecutive-error counter clears.
- `a`..`d` hold their last decoded value while `valid`=0.
- A cycle with `ready`=0 changes nothing; all pulses are 0 that cycle.
- The consecutive-error counter is internal and 4 bits wide.

## Timing
- Reset values: `a`..`d`=0, `valid`=0, `idle`=0, `error`=0, `locked`=0, `err_count`=0, consecutive-error counter=0, state=UNLOCKED.
- Latency: a symbol accepted at edge N drives its outputs after edge N.
  - Pulses are high for exactly the cycle between edges N and N+1.
  - Back-to-back `ready` gives one result per cycle with no bubbles.
- `locked` rises after the edge that accepts the locking IDLE; that IDLE's `idle` pulse appears in the same cycle.
- `locked` falls after the edge that accepts the `LOCK_ERRS`-th consecutive invalid symbol; that symbol's `error` pulse still appears in the same cycle.
- Saturation: with `err_count`=all-ones, further errors keep it at all-ones and `error` still pulses.
- Reset asserted mid-stream: all outputs go to reset values asynchronously. After release, the first accepted symbol is handled in UNLOCKED.
- At most one of `valid`, `idle`, `error` is high in any cycle.

## Structure
- Shared package `codec_pkg`, shared with `codificador`, holds:
  - the 16-entry 4B5B table;
  - the IDLE constant (5'b11111);
  - the state typedef (UNLOCKED, LOCKED).
- One natural combinational sub-module, `sym_lookup`:
  - input: 5-bit symbol;
  - outputs: 4-bit nibble, `is_data`, `is_idle`.
- The top level holds the FSM, counters and output registers.

## Test plan
- Reset, then symbol 01001 with `ready`=1, no prior IDLE -> `valid`=0, `locked`=0, `err_count`=0.
- IDLE, then the sixteen data symbols back-to-back -> `idle` pulse and `locked`=1 on the first cycle; then 16 consecutive `valid` pulses with nibbles 0..F in order.
- LOCKED; send 00000, 11110, 00000 -> `error`, `valid` (nibble 0), `error`; `err_count`=2; `locked` stays 1.
- LOCKED with `LOCK_ERRS`=3; send three 00001 symbols -> three `error` pulses; `locked` falls after the third. A following 11110 gives no `valid`; an IDLE relocks.
- `ERR_W`=2; 5 invalid symbols separated by data -> `err_count` goes 1, 2, 3 and stays 3; the fifth still pulses `error`.
- Assert `reset` low between clock edges mid-stream, with `a`..`d`=1011 -> all outputs 0 immediately. After release, state is UNLOCKED and `err_count` is 0.
